// File: rtl/div_calculate.sv
// div_calculate: sequential radix-2 restoring divider, one quotient bit per clock.
// Handshake: op_start (accepted in INIT), op_clear (abort/clear, any state), op_done.
// Optional feature macro: DIV_SIGNED_EN -- two's complement operands, magnitudes are
// divided and the signs are fixed up on entry and exit without extra latency.
`timescale 1ns/1ps
module div_calculate #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_start,
  input  logic             op_clear,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             op_done,
  output logic             div_by_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    INIT    = 2'b00,
    DIV     = 2'b01,
    RESULT  = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [5:0]       count, count_nxt;
  logic [WIDTH:0]   r_reg, r_nxt;
  logic [WIDTH-1:0] q_reg, q_nxt;
  logic [WIDTH-1:0] d_reg, d_nxt;
  logic [WIDTH-1:0] quotient_nxt, remainder_nxt;
  logic             op_done_nxt, div_by_zero_nxt;

  // Restoring step signals
  logic [WIDTH:0]   t_val;
  logic [WIDTH+1:0] diff;
  logic             no_borrow;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;

  // Subtraction in the same a + ~b + 1 form as the shared carry-lookahead adder;
  // the top bit of the result is the borrow.
  function automatic logic [WIDTH+1:0] cla_sub(input logic [WIDTH+1:0] a,
                                               input logic [WIDTH+1:0] b);
    return a + ~b + {{(WIDTH+1){1'b0}}, 1'b1};
  endfunction

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_q_nxt;
  logic neg_r, neg_r_nxt;

  // Absolute value; the most negative value maps onto itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // Conditional two's complement negation used for the exit fix-up.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction
`endif

  assign busy      = (state == DIV);
  assign t_val     = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign diff      = cla_sub({1'b0, t_val}, {2'b00, d_reg});
  assign no_borrow = ~diff[WIDTH+1];
  assign r_step    = no_borrow ? diff[WIDTH:0] : t_val;
  assign q_step    = {q_reg[WIDTH-2:0], no_borrow};

  // State and datapath registers; reset returns everything to zero immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= INIT;
      count       <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      op_done     <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      r_reg       <= r_nxt;
      q_reg       <= q_nxt;
      d_reg       <= d_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
      op_done     <= op_done_nxt;
      div_by_zero <= div_by_zero_nxt;
`ifdef DIV_SIGNED_EN
      neg_q       <= neg_q_nxt;
      neg_r       <= neg_r_nxt;
`endif
    end
  end

  // Next-state and next-value logic; op_clear overrides everything else.
  always_comb begin
    state_nxt       = state;
    count_nxt       = count;
    r_nxt           = r_reg;
    q_nxt           = q_reg;
    d_nxt           = d_reg;
    quotient_nxt    = quotient;
    remainder_nxt   = remainder;
    op_done_nxt     = op_done;
    div_by_zero_nxt = div_by_zero;
`ifdef DIV_SIGNED_EN
    neg_q_nxt       = neg_q;
    neg_r_nxt       = neg_r;
`endif
    if (op_clear) begin
      state_nxt       = INIT;
      count_nxt       = '0;
      r_nxt           = '0;
      q_nxt           = '0;
      d_nxt           = '0;
      quotient_nxt    = '0;
      remainder_nxt   = '0;
      op_done_nxt     = 1'b0;
      div_by_zero_nxt = 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_nxt       = 1'b0;
      neg_r_nxt       = 1'b0;
`endif
    end else begin
      case (state)
        INIT: begin
          if (op_start) begin
            if (divisor == '0) begin
              // Divide by zero short-circuits straight to a flagged result.
              state_nxt       = RESULT;
              quotient_nxt    = '1;
              remainder_nxt   = dividend;
              op_done_nxt     = 1'b1;
              div_by_zero_nxt = 1'b1;
            end else begin
              state_nxt = DIV;
              count_nxt = '0;
              r_nxt     = '0;
`ifdef DIV_SIGNED_EN
              q_nxt     = magnitude(dividend);
              d_nxt     = magnitude(divisor);
              neg_q_nxt = dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r_nxt = dividend[WIDTH-1];
`else
              q_nxt     = dividend;
              d_nxt     = divisor;
`endif
            end
          end
        end
        DIV: begin
          r_nxt     = r_step;
          q_nxt     = q_step;
          count_nxt = count + 6'd1;
          if (count == LAST_STEP) begin
            state_nxt     = RESULT;
            op_done_nxt   = 1'b1;
`ifdef DIV_SIGNED_EN
            quotient_nxt  = apply_sign(q_step, neg_q);
            remainder_nxt = apply_sign(r_step[WIDTH-1:0], neg_r);
`else
            quotient_nxt  = q_step;
            remainder_nxt = r_step[WIDTH-1:0];
`endif
          end
        end
        RESULT: begin
          state_nxt = RESULT;
        end
        default: begin
          state_nxt = INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_calculate.sv
// Self-checking bench for div_calculate: directed cases plus randomized operands
// compared against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_div_calculate;

  logic        clk;
  logic        reset_n;
  logic        op_start;
  logic        op_clear;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        op_done;
  logic        div_by_zero;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  div_calculate #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op_start    (op_start),
    .op_clear    (op_clear),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .op_done     (op_done),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model straight from the arithmetic definition.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
`ifdef DIV_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  task automatic do_clear();
    @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_clear = 1'b0;
    check("clear_done", op_done, 1'b0);
    check("clear_q_r", {quotient, remainder}, 64'd0);
    check("clear_dbz_busy", {div_by_zero, busy}, 2'b00);
  endtask

  // One full operation; disturb scrambles inputs and pulses op_start while dividing.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input bit disturb);
    int  edges;
    bit  busy_bad;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    op_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_start = 1'b0;
    edges    = 1;
    busy_bad = 1'b0;
    if (b == 32'd0) begin
      check({tag, "_dbz_done"}, {op_done, div_by_zero, busy}, 3'b110);
    end else begin
      while (!op_done && edges < 40) begin
        if (!busy) busy_bad = 1'b1;
        if (disturb) begin
          dividend = $urandom;
          divisor  = $urandom;
          op_start = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        @(negedge clk);
        edges++;
      end
      op_start = 1'b0;
      check({tag, "_latency"}, edges, 33);
      check({tag, "_busy_during"}, busy_bad, 1'b0);
      check({tag, "_end_flags"}, {op_done, div_by_zero, busy}, 3'b100);
    end
    check({tag, "_quot"}, quotient, exp_q);
    check({tag, "_rem"}, remainder, exp_r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, eq, er;
    reset_n  = 1'b0;
    op_start = 1'b0;
    op_clear = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {quotient, remainder}, 64'd0);
    check("reset_flags", {op_done, div_by_zero, busy}, 3'b000);
    reset_n = 1'b1;

    run_div("u100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    do_clear();

    run_div("ffff_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_clear();
    run_div("u5_9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
    do_clear();

    // Divide by zero: result must hold for 20 cycles with op_start pulsing.
    run_div("div0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
    for (int i = 0; i < 20; i++) begin
      op_start = 1'(i & 1);
      @(posedge clk);
      @(negedge clk);
      check("div0_hold", {op_done, div_by_zero, quotient, remainder},
            {2'b11, 32'hFFFF_FFFF, 32'd5});
    end
    op_start = 1'b0;
    do_clear();

    // Abort at E10 with op_clear.
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    op_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_start = 1'b0;
    repeat (9) @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_clear = 1'b0;
    check("abort_flags", {op_done, div_by_zero, busy}, 3'b000);
    check("abort_outputs", {quotient, remainder}, 64'd0);
    run_div("u1000_3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
    do_clear();

`ifdef DIV_SIGNED_EN
    run_div("neg7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_clear();
    run_div("minint_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    do_clear();
`else
    run_div("big7_2", 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
    do_clear();
`endif

    // Asynchronous reset in the middle of a clock cycle around E20.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    op_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_flags", {op_done, div_by_zero, busy}, 3'b000);
    check("async_rst_outputs", {quotient, remainder}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Operands and op_start disturbed while dividing must not change the result.
    run_div("disturb", 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    do_clear();

    // Randomized operands, mixing wide and narrow divisors.
    for (int k = 0; k < 30; k++) begin
      a = $urandom;
      case (k % 4)
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 255));
        2: b = {$urandom} >> $urandom_range(0, 31);
        default: b = (k == 7) ? 32'd0 : 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      endcase
      ref_div(a, b, eq, er);
      run_div("rand", a, b, eq, er, 1'b0);
      do_clear();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
